// File: rtl/cpc_video_pkg.sv
// ----------------------------------------------------------------------------
// cpc_video_pkg
// Shared definitions for the CPC video fetch block:
//   - fixed interface widths (CRTC memory/raster address, video RAM address)
//   - fetch FSM state encoding
//   - CRTC-to-video-RAM address mapping function
// ----------------------------------------------------------------------------
package cpc_video_pkg;

   localparam int MA_W  = 14;   // CRTC memory address width
   localparam int RA_W  = 5;    // CRTC raster address width
   localparam int ADR_W = 16;   // video RAM byte address width
   localparam int PIX_W = 16;   // two fetched bytes per character

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD0  = 2'd1,
      RD1  = 2'd2,
      OUT  = 2'd3
   } state_t;

   // Video RAM byte address: {ma[13:12], ra[2:0], ma[9:0], b}.
   // Callers pass only the bits that take part; ma[11:10] and ra[4:3]
   // never reach the address.
   function automatic logic [ADR_W-1:0] map_addr(
      input logic [1:0] ma_hi,
      input logic [2:0] ra_lo,
      input logic [9:0] ma_lo,
      input logic       b
   );
      return {ma_hi, ra_lo, ma_lo, b};
   endfunction

endpackage

// File: rtl/cpc_video_addr.sv
// ----------------------------------------------------------------------------
// cpc_video_addr
// Combinational CRTC address -> video RAM byte address mapper.
// Ports:
//   ma_i   [13:0] CRTC memory address
//   ra_i   [4:0]  CRTC raster address
//   b_i           byte select within the character (0 = first, 1 = second)
//   adr_o  [15:0] video RAM byte address
// ----------------------------------------------------------------------------
module cpc_video_addr
   import cpc_video_pkg::*;
(
   input  logic [MA_W-1:0]  ma_i,
   input  logic [RA_W-1:0]  ra_i,
   input  logic             b_i,
   output logic [ADR_W-1:0] adr_o
);

   // These address bits are deliberately dropped by the mapping.
   logic w_unused_bits;
   assign w_unused_bits = ^{ma_i[11:10], ra_i[4:3]};

   assign adr_o = map_addr(ma_i[13:12], ra_i[2:0], ma_i[9:0], b_i);

endmodule

// File: rtl/cpc_video_fetch.sv
// ----------------------------------------------------------------------------
// cpc_video_fetch
// Per-character video fetch: on each accepted CRTC character strobe, reads
// two bytes from video RAM (when display is enabled) and presents them with
// the latched de/hsync/vsync as a single pix_valid_o pulse.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   char_stb_i                        new character position strobe
//   ma_i[13:0], ra_i[4:0]             CRTC memory / raster address
//   de_i, hsync_i, vsync_i            CRTC display enable and syncs
//   mem_adr_o[15:0], mem_stb_o        video RAM read request (held to ack)
//   mem_ack_i, mem_dat_i[7:0]         read acknowledge and data
//   pix_dat_o[15:0]                   {byte0, byte1}
//   pix_valid_o                       one-cycle update pulse
//   pix_de_o, hsync_o, vsync_o        latched de/syncs, aligned to pulse
//   ovf_o                             sticky overrun (strobe while busy)
// ----------------------------------------------------------------------------
module cpc_video_fetch
   import cpc_video_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             char_stb_i,
   input  logic [13:0]      ma_i,
   input  logic [4:0]       ra_i,
   input  logic             de_i,
   input  logic             hsync_i,
   input  logic             vsync_i,
   output logic [15:0]      mem_adr_o,
   output logic             mem_stb_o,
   input  logic             mem_ack_i,
   input  logic [7:0]       mem_dat_i,
   output logic [15:0]      pix_dat_o,
   output logic             pix_valid_o,
   output logic             pix_de_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             ovf_o
);

   state_t           r_state;
   logic [MA_W-1:0]  r_ma;
   logic [RA_W-1:0]  r_ra;
   logic             r_de;
   logic             r_hs;
   logic             r_vs;
   logic [7:0]       r_byte0;
   logic [ADR_W-1:0] r_adr;
   logic             r_stb;
   logic [PIX_W-1:0] r_pix_dat;
   logic             r_pix_valid;
   logic             r_pix_de;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_ovf;

   logic [MA_W-1:0]  w_map_ma;
   logic [RA_W-1:0]  w_map_ra;
   logic             w_map_b;
   logic [ADR_W-1:0] w_map_adr;

   // One mapper serves both bytes: in IDLE it sees the live CRTC inputs
   // (byte 0 address, registered on the strobe); afterwards it sees the
   // latched copy with b=1, registered when byte 0 is acknowledged.
   assign w_map_ma = (r_state == IDLE) ? ma_i : r_ma;
   assign w_map_ra = (r_state == IDLE) ? ra_i : r_ra;
   assign w_map_b  = (r_state != IDLE);

   cpc_video_addr u_addr (
      .ma_i  (w_map_ma),
      .ra_i  (w_map_ra),
      .b_i   (w_map_b),
      .adr_o (w_map_adr)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_ma        <= '0;
         r_ra        <= '0;
         r_de        <= 1'b0;
         r_hs        <= 1'b0;
         r_vs        <= 1'b0;
         r_byte0     <= '0;
         r_adr       <= '0;
         r_stb       <= 1'b0;
         r_pix_dat   <= '0;
         r_pix_valid <= 1'b0;
         r_pix_de    <= 1'b0;
         r_hsync     <= 1'b0;
         r_vsync     <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_pix_valid <= 1'b0;

         // A strobe outside IDLE is dropped; only the sticky flag records it.
         if (char_stb_i && (r_state != IDLE))
            r_ovf <= 1'b1;

         unique case (r_state)
            IDLE: begin
               if (char_stb_i) begin
                  r_ma <= ma_i;
                  r_ra <= ra_i;
                  r_de <= de_i;
                  r_hs <= hsync_i;
                  r_vs <= vsync_i;
                  if (de_i) begin
                     r_adr   <= w_map_adr;
                     r_stb   <= 1'b1;
                     r_state <= RD0;
                  end else begin
                     // Blanked character: no RAM access, present zeros now.
                     r_pix_dat   <= '0;
                     r_pix_de    <= 1'b0;
                     r_hsync     <= hsync_i;
                     r_vsync     <= vsync_i;
                     r_pix_valid <= 1'b1;
                     r_state     <= OUT;
                  end
               end
            end
            RD0: begin
               if (mem_ack_i) begin
                  r_byte0 <= mem_dat_i;
                  r_adr   <= w_map_adr;
                  r_state <= RD1;
               end
            end
            RD1: begin
               if (mem_ack_i) begin
                  r_stb       <= 1'b0;
                  r_pix_dat   <= {r_byte0, mem_dat_i};
                  r_pix_de    <= r_de;
                  r_hsync     <= r_hs;
                  r_vsync     <= r_vs;
                  r_pix_valid <= 1'b1;
                  r_state     <= OUT;
               end
            end
            OUT: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign mem_adr_o   = r_adr;
   assign mem_stb_o   = r_stb;
   assign pix_dat_o   = r_pix_dat;
   assign pix_valid_o = r_pix_valid;
   assign pix_de_o    = r_pix_de;
   assign hsync_o     = r_hsync;
   assign vsync_o     = r_vsync;
   assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_cpc_video_fetch.sv
// ----------------------------------------------------------------------------
// tb_cpc_video_fetch
// Self-checking bench for cpc_video_fetch. A transaction-level model turns
// each character strobe into a timeline (request window, addresses, ack
// cycles, pixel pulse) using the documented latency rules, then every cycle
// the DUT outputs are compared with that timeline.
// ----------------------------------------------------------------------------
module tb_cpc_video_fetch;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        char_stb_i;
   logic [13:0] ma_i;
   logic [4:0]  ra_i;
   logic        de_i, hsync_i, vsync_i;
   logic [15:0] mem_adr_o;
   logic        mem_stb_o;
   logic        mem_ack_i;
   logic [7:0]  mem_dat_i;
   logic [15:0] pix_dat_o;
   logic        pix_valid_o, pix_de_o, hsync_o, vsync_o, ovf_o;

   always #5 clk_i = ~clk_i;

   cpc_video_fetch dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .char_stb_i  (char_stb_i),
      .ma_i        (ma_i),
      .ra_i        (ra_i),
      .de_i        (de_i),
      .hsync_i     (hsync_i),
      .vsync_i     (vsync_i),
      .mem_adr_o   (mem_adr_o),
      .mem_stb_o   (mem_stb_o),
      .mem_ack_i   (mem_ack_i),
      .mem_dat_i   (mem_dat_i),
      .pix_dat_o   (pix_dat_o),
      .pix_valid_o (pix_valid_o),
      .pix_de_o    (pix_de_o),
      .hsync_o     (hsync_o),
      .vsync_o     (vsync_o),
      .ovf_o       (ovf_o)
   );

   // Per-cycle expected timeline, indexed by cycle number k.
   localparam int NP = 8192;
   bit          a_stb [NP];
   logic [15:0] a_adr [NP];
   bit          a_ack [NP];
   logic [7:0]  a_dat [NP];
   bit          a_vld [NP];
   logic [18:0] a_pix [NP];   // {dat[15:0], de, hs, vs}

   int          k;
   int          free_k;       // first cycle a new strobe is accepted
   bit          m_ovf;
   logic [15:0] h_adr;        // held expected address
   logic [18:0] h_pix;        // held expected pixel outputs
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, k, got, exp);
      end
   endtask

   // Address rule written as plain arithmetic on the CRTC fields.
   function automatic logic [15:0] ref_addr(input logic [13:0] ma, input logic [4:0] ra, input int b);
      int a;
      a = ((int'(ma) >> 12) & 3) * 16384 + (int'(ra) & 7) * 2048 + (int'(ma) & 1023) * 2 + b;
      return 16'(a);
   endfunction

   task automatic clear_from(input int start);
      for (int t = start; t < start + 64 && t < NP; t++) begin
         a_stb[t] = 1'b0;
         a_ack[t] = 1'b0;
         a_vld[t] = 1'b0;
      end
   endtask

   // One clock cycle: check outputs for cycle k, then drive inputs for it.
   task automatic period(input bit s, input logic [13:0] ma, input logic [4:0] ra,
                         input bit de, input bit hs, input bit vs,
                         input int w0, input int w1,
                         input logic [7:0] d0, input logic [7:0] d1);
      int vt;
      @(negedge clk_i);
      if (a_stb[k]) h_adr = a_adr[k];
      if (a_vld[k]) h_pix = a_pix[k];
      chk("mem_stb", 32'(mem_stb_o), 32'(a_stb[k]));
      chk("mem_adr", 32'(mem_adr_o), 32'(h_adr));
      chk("pix_valid", 32'(pix_valid_o), 32'(a_vld[k]));
      chk("pix_dat", 32'(pix_dat_o), 32'(h_pix[18:3]));
      chk("de_sync", 32'({pix_de_o, hsync_o, vsync_o}), 32'(h_pix[2:0]));
      chk("ovf", 32'(ovf_o), 32'(m_ovf));
      if (a_vld[k])
         $display("pixel cycle=%0d dat=%h de=%b hs=%b vs=%b ovf=%b",
                  k, pix_dat_o, pix_de_o, hsync_o, vsync_o, ovf_o);

      char_stb_i = s;
      ma_i       = ma;
      ra_i       = ra;
      de_i       = de;
      hsync_i    = hs;
      vsync_i    = vs;
      if (a_stb[k]) begin
         mem_ack_i = a_ack[k];
         mem_dat_i = a_ack[k] ? a_dat[k] : 8'($urandom);
      end else begin
         // Stray acks while no request is outstanding must be ignored.
         mem_ack_i = ($urandom_range(0, 3) == 0);
         mem_dat_i = 8'($urandom);
      end

      if (s) begin
         if (k >= free_k) begin
            if (de) begin
               for (int t = k + 1; t <= k + 2 + w0 + w1; t++) begin
                  a_stb[t] = 1'b1;
                  a_adr[t] = (t <= k + 1 + w0) ? ref_addr(ma, ra, 0) : ref_addr(ma, ra, 1);
               end
               a_ack[k + 1 + w0]      = 1'b1;
               a_dat[k + 1 + w0]      = d0;
               a_ack[k + 2 + w0 + w1] = 1'b1;
               a_dat[k + 2 + w0 + w1] = d1;
               vt = k + 3 + w0 + w1;
               a_vld[vt] = 1'b1;
               a_pix[vt] = {d0, d1, 1'b1, hs, vs};
               free_k    = vt + 1;
            end else begin
               a_vld[k + 1] = 1'b1;
               a_pix[k + 1] = {16'h0000, 1'b0, hs, vs};
               free_k       = k + 2;
            end
         end else begin
            m_ovf = 1'b1;
         end
      end
      k++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         period(1'b0, 14'h0, 5'h0, 1'b0, 1'b0, 1'b0, 0, 0, 8'h00, 8'h00);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stb"},   32'(mem_stb_o),   32'd0);
      chk({tag, "_adr"},   32'(mem_adr_o),   32'd0);
      chk({tag, "_dat"},   32'(pix_dat_o),   32'd0);
      chk({tag, "_valid"}, 32'(pix_valid_o), 32'd0);
      chk({tag, "_de"},    32'(pix_de_o),    32'd0);
      chk({tag, "_hs"},    32'(hsync_o),     32'd0);
      chk({tag, "_vs"},    32'(vsync_o),     32'd0);
      chk({tag, "_ovf"},   32'(ovf_o),       32'd0);
   endtask

   initial begin
      rst_i      = 1'b1;
      char_stb_i = 1'b0;
      ma_i = '0; ra_i = '0; de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
      mem_ack_i  = 1'b0;
      mem_dat_i  = '0;
      k = 0; free_k = 0; m_ovf = 1'b0; h_adr = '0; h_pix = '0;
      clear_from(0);
      for (int t = 0; t < NP; t++) begin
         a_stb[t] = 1'b0; a_ack[t] = 1'b0; a_vld[t] = 1'b0;
         a_adr[t] = '0; a_dat[t] = '0; a_pix[t] = '0;
      end

      repeat (3) @(negedge clk_i);
      chk_all_zero("reset");
      rst_i = 1'b0;

      // Zero-wait fetch with known data.
      period(1'b1, 14'h3005, 5'd2, 1'b1, 1'b0, 1'b0, 0, 0, 8'hA5, 8'h5A);
      idle(5);
      chk("zero_wait_dat", 32'(pix_dat_o), 32'h0000A55A);

      // Three wait cycles per byte.
      period(1'b1, 14'h3005, 5'd2, 1'b1, 1'b0, 1'b1, 3, 3, 8'h3C, 8'hC3);
      idle(12);

      // Blanked character with hsync.
      period(1'b1, 14'h1234, 5'd5, 1'b0, 1'b1, 1'b0, 0, 0, 8'h00, 8'h00);
      idle(3);

      // Second strobe lands in RD1: dropped, overrun flagged.
      period(1'b1, 14'h0123, 5'd1, 1'b1, 1'b0, 1'b0, 0, 0, 8'h11, 8'h22);
      idle(1);
      period(1'b1, 14'h2222, 5'd3, 1'b1, 1'b1, 1'b1, 0, 0, 8'h99, 8'h88);
      idle(6);

      // Reset pulsed while in RD1.
      period(1'b1, 14'h3FFF, 5'd7, 1'b1, 1'b1, 1'b1, 0, 2, 8'h77, 8'h66);
      idle(1);
      @(negedge clk_i);
      rst_i      = 1'b1;
      char_stb_i = 1'b0;
      mem_ack_i  = 1'b0;
      #1;
      chk_all_zero("midreset");
      clear_from(k);
      h_adr = '0; h_pix = '0; m_ovf = 1'b0; free_k = 0;
      @(negedge clk_i);
      chk("midreset_valid", 32'(pix_valid_o), 32'd0);
      rst_i = 1'b0;
      k += 2;
      clear_from(k);
      idle(4);

      // Ignored address bits.
      period(1'b1, 14'h0FFF, 5'd31, 1'b1, 1'b0, 1'b0, 0, 1, 8'h01, 8'h02);
      idle(6);
      chk("masked_adr", 32'(mem_adr_o), 32'h00003FFF);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         bit s;
         s = ($urandom_range(0, 2) == 0);
         period(s, 14'($urandom), 5'($urandom), ($urandom_range(0, 3) != 0),
                1'($urandom), 1'($urandom),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                8'($urandom), 8'($urandom));
      end
      idle(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
